// File: rtl/cve2_pmp_seq_pkg.sv
// Shared types for the sequential multi-channel PMP checker.
// Privilege, access type, region config and scan FSM states.
package cve2_pmp_seq_pkg;

  typedef enum logic [1:0] {
    PRIV_LVL_U = 2'b00,
    PRIV_LVL_S = 2'b01,
    PRIV_LVL_H = 2'b10,
    PRIV_LVL_M = 2'b11
  } priv_lvl_e;

  typedef enum logic [1:0] {
    PMP_ACC_EXEC  = 2'b00,
    PMP_ACC_WRITE = 2'b01,
    PMP_ACC_READ  = 2'b10
  } pmp_req_e;

  typedef enum logic [1:0] {
    PMP_MODE_OFF   = 2'b00,
    PMP_MODE_TOR   = 2'b01,
    PMP_MODE_NA4   = 2'b10,
    PMP_MODE_NAPOT = 2'b11
  } pmp_cfg_mode_e;

  typedef struct packed {
    logic          lock;
    pmp_cfg_mode_e mode;
    logic          exec;
    logic          write;
    logic          read;
  } pmp_cfg_t;

  typedef struct packed {
    logic rlb;
    logic mmwp;
    logic mml;
  } pmp_mseccfg_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SCAN = 2'b01,
    RESP = 2'b10
  } pmp_seq_state_e;

  localparam int unsigned PMP_ADDR_W = 34;

endpackage

// File: rtl/cve2_pmp_region_chk.sv
// Combinational match and permission check for one PMP region.
// Handles TOR/NA4/NAPOT and the MML permission encodings.
import cve2_pmp_seq_pkg::*;

module cve2_pmp_region_chk #(
  parameter int unsigned PMPGranularity = 0
) (
  input  pmp_cfg_t    cfg,
  input  logic [33:0] addr,
  input  logic [33:0] prev_addr,
  input  logic [33:0] req_addr,
  input  pmp_req_e    req_type,
  input  priv_lvl_e   req_priv,
  input  logic        mml,
  output logic        match,
  output logic        perm_ok
);

  localparam int unsigned Lsb = PMPGranularity + 2;

  logic [33:0]  nmask;
  logic [33:Lsb] diff;
  logic         ign;
  logic         rd, wr, ex, is_m, perm;
  logic         unused_low;

  // NAPOT: bit b is compared only once a zero has appeared below it
  always_comb begin
    ign   = 1'b1;
    nmask = '0;
    for (int b = 2; b < 34; b++) begin
      nmask[b] = !ign;
      ign      = ign & addr[b];
    end
  end

  assign diff = (req_addr[33:Lsb] ^ addr[33:Lsb]) & nmask[33:Lsb];

  always_comb begin
    match = 1'b0;
    unique case (cfg.mode)
      PMP_MODE_TOR: match = (req_addr[33:Lsb] >= prev_addr[33:Lsb]) &&
                            (req_addr[33:Lsb] <  addr[33:Lsb]);
      PMP_MODE_NA4:   match = (req_addr[33:Lsb] == addr[33:Lsb]);
      PMP_MODE_NAPOT: match = ~|diff;
      default:        match = 1'b0;
    endcase
  end

  assign rd   = (req_type == PMP_ACC_READ);
  assign wr   = (req_type == PMP_ACC_WRITE);
  assign ex   = (req_type == PMP_ACC_EXEC);
  assign is_m = (req_priv == PRIV_LVL_M);
  assign perm = (rd & cfg.read) | (wr & cfg.write) | (ex & cfg.exec);

  always_comb begin
    perm_ok = 1'b0;
    if (!mml) begin
      perm_ok = is_m ? (~cfg.lock | perm) : perm;
    end else if (!cfg.read && cfg.write) begin
      unique case ({cfg.lock, cfg.exec})
        2'b00:   perm_ok = rd | (wr & is_m);
        2'b01:   perm_ok = rd | wr;
        2'b10:   perm_ok = ex;
        default: perm_ok = ex | (rd & is_m);
      endcase
    end else if (cfg.lock & cfg.read & cfg.write & cfg.exec) begin
      perm_ok = rd;
    end else begin
      perm_ok = perm & (is_m ? cfg.lock : ~cfg.lock);
    end
  end

  assign unused_low = ^{req_addr[Lsb-1:0], prev_addr[Lsb-1:0],
                        addr[1:0], nmask[Lsb-1:0]};

endmodule

// File: rtl/cve2_pmp_seq.sv
// Sequential multi-channel PMP checker, RegionsPerCycle regions per cycle.
// Optional per-channel hit cache: define CVE2_PMP_HITCACHE_EN.
import cve2_pmp_seq_pkg::*;

module cve2_pmp_seq #(
  parameter int unsigned PMPGranularity  = 0,
  parameter int unsigned PMPNumChan      = 2,
  parameter int unsigned PMPNumRegions   = 16,
  parameter int unsigned RegionsPerCycle = 4,
  localparam int unsigned RegionW =
    (PMPNumRegions > 1) ? $clog2(PMPNumRegions) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  pmp_cfg_t              csr_pmp_cfg_i  [PMPNumRegions],
  input  logic [33:0]           csr_pmp_addr_i [PMPNumRegions],
  input  pmp_mseccfg_t          csr_pmp_mseccfg_i,
  input  logic                  csr_pmp_wr_i,
  input  logic [PMPNumChan-1:0] req_valid_i,
  output logic [PMPNumChan-1:0] req_ready_o,
  input  logic [33:0]           req_addr_i [PMPNumChan],
  input  pmp_req_e              req_type_i [PMPNumChan],
  input  priv_lvl_e             req_priv_i [PMPNumChan],
  output logic [PMPNumChan-1:0] rsp_valid_o,
  output logic [PMPNumChan-1:0] rsp_err_o,
  output logic [PMPNumChan-1:0] rsp_match_o,
  output logic [RegionW-1:0]    rsp_region_o [PMPNumChan]
);

  localparam int unsigned NumGroups = PMPNumRegions / RegionsPerCycle;
  localparam int unsigned GrpW = (NumGroups > 1) ? $clog2(NumGroups) : 1;
  localparam int unsigned Lsb = PMPGranularity + 2;

  logic [33:0] prev_addr [PMPNumRegions];
  logic        unused_rlb;

  assign unused_rlb = csr_pmp_mseccfg_i.rlb;

  // TOR lower bound ignores group boundaries
  for (genvar r = 0; r < PMPNumRegions; r++) begin : g_prev
    if (r == 0) begin : g_zero
      assign prev_addr[r] = '0;
    end else begin : g_prev_r
      assign prev_addr[r] = csr_pmp_addr_i[r-1];
    end
  end

  for (genvar c = 0; c < PMPNumChan; c++) begin : g_chan
    pmp_seq_state_e       state_q;
    logic [GrpW-1:0]      grp_q;
    logic [33:0]          addr_q;
    pmp_req_e             type_q;
    priv_lvl_e            priv_q;
    logic                 valid_q, err_q, match_q;
    logic [RegionW-1:0]   region_q;
    logic [RegionW-1:0]   base;
    logic [RegionsPerCycle-1:0] s_match, s_ok;
    logic                 hit, hit_err;
    logic [RegionW-1:0]   hit_region;
    logic                 cache_hit, cache_err, cache_match;
    logic [RegionW-1:0]   cache_region;

    assign base = RegionW'(grp_q) * RegionW'(RegionsPerCycle);

    for (genvar s = 0; s < RegionsPerCycle; s++) begin : g_slot
      logic [RegionW-1:0] idx;
      assign idx = base + RegionW'(s);
      cve2_pmp_region_chk #(
        .PMPGranularity(PMPGranularity)
      ) u_chk (
        .cfg      (csr_pmp_cfg_i[idx]),
        .addr     (csr_pmp_addr_i[idx]),
        .prev_addr(prev_addr[idx]),
        .req_addr (addr_q),
        .req_type (type_q),
        .req_priv (priv_q),
        .mml      (csr_pmp_mseccfg_i.mml),
        .match    (s_match[s]),
        .perm_ok  (s_ok[s])
      );
    end

    always_comb begin
      hit        = 1'b0;
      hit_err    = 1'b0;
      hit_region = '0;
      for (int s = RegionsPerCycle - 1; s >= 0; s--) begin
        if (s_match[s]) begin
          hit        = 1'b1;
          hit_err    = ~s_ok[s];
          hit_region = base + RegionW'(s);
        end
      end
    end

`ifdef CVE2_PMP_HITCACHE_EN
    logic               c_valid, c_err, c_match;
    logic [33:Lsb]      c_addr;
    pmp_req_e           c_type;
    priv_lvl_e          c_priv;
    logic [RegionW-1:0] c_region;

    assign cache_hit = c_valid & ~csr_pmp_wr_i &
                       (c_addr == req_addr_i[c][33:Lsb]) &
                       (c_type == req_type_i[c]) &
                       (c_priv == req_priv_i[c]);
    assign cache_err    = c_err;
    assign cache_match  = c_match;
    assign cache_region = c_region;

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        c_valid  <= 1'b0;
        c_addr   <= '0;
        c_type   <= PMP_ACC_EXEC;
        c_priv   <= PRIV_LVL_M;
        c_err    <= 1'b0;
        c_match  <= 1'b0;
        c_region <= '0;
      end else begin
        if (state_q == RESP) begin
          c_valid  <= 1'b1;
          c_addr   <= addr_q[33:Lsb];
          c_type   <= type_q;
          c_priv   <= priv_q;
          c_err    <= err_q;
          c_match  <= match_q;
          c_region <= region_q;
        end
        // invalidation overrides a same-cycle fill
        if (csr_pmp_wr_i) c_valid <= 1'b0;
      end
    end
`else
    assign cache_hit    = 1'b0;
    assign cache_err    = 1'b0;
    assign cache_match  = 1'b0;
    assign cache_region = '0;
`endif

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        state_q  <= IDLE;
        grp_q    <= '0;
        addr_q   <= '0;
        type_q   <= PMP_ACC_EXEC;
        priv_q   <= PRIV_LVL_M;
        valid_q  <= 1'b0;
        err_q    <= 1'b0;
        match_q  <= 1'b0;
        region_q <= '0;
      end else begin
        valid_q <= 1'b0;
        unique case (state_q)
          IDLE: begin
            if (req_valid_i[c]) begin
              addr_q <= req_addr_i[c];
              type_q <= req_type_i[c];
              priv_q <= req_priv_i[c];
              grp_q  <= '0;
              if (cache_hit) begin
                state_q  <= RESP;
                valid_q  <= 1'b1;
                err_q    <= cache_err;
                match_q  <= cache_match;
                region_q <= cache_region;
              end else begin
                state_q <= SCAN;
              end
            end
          end
          SCAN: begin
            if (csr_pmp_wr_i) begin
              grp_q <= '0;
            end else if (hit) begin
              state_q  <= RESP;
              valid_q  <= 1'b1;
              err_q    <= hit_err;
              match_q  <= 1'b1;
              region_q <= hit_region;
            end else if (grp_q == GrpW'(NumGroups - 1)) begin
              state_q  <= RESP;
              valid_q  <= 1'b1;
              err_q    <= csr_pmp_mseccfg_i.mmwp |
                          (priv_q != PRIV_LVL_M);
              match_q  <= 1'b0;
              region_q <= '0;
            end else begin
              grp_q <= grp_q + GrpW'(1);
            end
          end
          RESP:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end

    assign req_ready_o[c]  = (state_q == IDLE);
    assign rsp_valid_o[c]  = valid_q;
    assign rsp_err_o[c]    = err_q;
    assign rsp_match_o[c]  = match_q;
    assign rsp_region_o[c] = region_q;
  end

endmodule

// File: tb/tb_cve2_pmp_seq.sv
// Directed bench for cve2_pmp_seq: 16 regions, 4 per cycle, G=0.
// Latency counted in cycles after the accept edge (accept cycle = T).
import cve2_pmp_seq_pkg::*;

module tb_cve2_pmp_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  pmp_cfg_t     cfg   [16];
  logic [33:0]  paddr [16];
  pmp_mseccfg_t msec;
  logic         wr;
  logic [1:0]   vld, rdy, rv, re, rm;
  logic [33:0]  ra [2];
  pmp_req_e     rt [2];
  priv_lvl_e    rp [2];
  logic [3:0]   rr [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cve2_pmp_seq #(
    .PMPGranularity (0),
    .PMPNumChan     (2),
    .PMPNumRegions  (16),
    .RegionsPerCycle(4)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .csr_pmp_cfg_i    (cfg),
    .csr_pmp_addr_i   (paddr),
    .csr_pmp_mseccfg_i(msec),
    .csr_pmp_wr_i     (wr),
    .req_valid_i      (vld),
    .req_ready_o      (rdy),
    .req_addr_i       (ra),
    .req_type_i       (rt),
    .req_priv_i       (rp),
    .rsp_valid_o      (rv),
    .rsp_err_o        (re),
    .rsp_match_o      (rm),
    .rsp_region_o     (rr)
  );

  task automatic chk(input string tag, input logic [33:0] obs,
                     input logic [33:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_cfg();
    for (int i = 0; i < 16; i++) begin
      cfg[i]   = '0;
      paddr[i] = '0;
    end
    msec = '0;
  endtask

  task automatic commit();
    wr = 1'b1;
    @(posedge clk); #1;
    wr = 1'b0;
  endtask

  task automatic issue(input string tag, input int ch, input logic [33:0] a,
                       input pmp_req_e t, input priv_lvl_e p);
    chk({tag, ".rdy_idle"}, 34'(rdy[ch]), 34'd1);
    vld[ch] = 1'b1;
    ra[ch]  = a;
    rt[ch]  = t;
    rp[ch]  = p;
    @(posedge clk); #1;
    vld[ch] = 1'b0;
    chk({tag, ".rdy_busy"}, 34'(rdy[ch]), 34'd0);
  endtask

  task automatic wait_rsp(input string tag, input int ch, input int lat0,
                          input int elat, input logic eerr,
                          input logic emat, input logic [3:0] ereg);
    int lat;
    lat = lat0;
    while (rv[ch] !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".lat"}, 34'(lat), 34'(elat));
    chk({tag, ".err"}, 34'(re[ch]), 34'(eerr));
    chk({tag, ".match"}, 34'(rm[ch]), 34'(emat));
    chk({tag, ".region"}, 34'(rr[ch]), 34'(ereg));
    @(posedge clk); #1;
    chk({tag, ".pulse"}, 34'(rv[ch]), 34'd0);
  endtask

  task automatic set_r9(input logic w);
    cfg[9]   = '{lock: 1'b0, mode: PMP_MODE_NAPOT, exec: 1'b0,
                 write: w, read: 1'b1};
    paddr[9] = 34'h0_8000_07FC;
  endtask

  initial begin
    int l0, l1, seen;
    logic e0, e1;
    logic [3:0] g1;
    rst_n = 1'b0;
    wr    = 1'b0;
    vld   = '0;
    for (int i = 0; i < 2; i++) begin
      ra[i] = '0;
      rt[i] = PMP_ACC_READ;
      rp[i] = PRIV_LVL_M;
    end
    clear_cfg();
    @(posedge clk); @(posedge clk); #1;
    chk("rst.valid", 34'(rv), 34'd0);
    chk("rst.err", 34'(re), 34'd0);
    chk("rst.match", 34'(rm), 34'd0);
    chk("rst.region", 34'({rr[1], rr[0]}), 34'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst.ready", 34'(rdy), 34'd3);

    // all regions OFF, M-mode read
    issue("t1", 0, 34'h0_0000_1000, PMP_ACC_READ, PRIV_LVL_M);
    wait_rsp("t1", 0, 1, 5, 1'b0, 1'b0, 4'd0);

    // NAPOT 4 KiB read-only, U write
    set_r9(1'b0);
    commit();
    issue("t2", 0, 34'h0_8000_0010, PMP_ACC_WRITE, PRIV_LVL_U);
    wait_rsp("t2", 0, 1, 4, 1'b1, 1'b1, 4'd9);

    // CSR write mid-scan restarts with new config
    commit();
    issue("t4", 0, 34'h0_8000_0010, PMP_ACC_WRITE, PRIV_LVL_U);
    @(posedge clk); #1;
    wr = 1'b1;
    set_r9(1'b1);
    @(posedge clk); #1;
    wr = 1'b0;
    wait_rsp("t4", 0, 3, 6, 1'b0, 1'b1, 4'd9);

    // TOR [0x100,0x200) RX, NA4 0x104 RW at regions 2 and 5
    clear_cfg();
    cfg[1]   = '{lock: 1'b0, mode: PMP_MODE_TOR, exec: 1'b1,
                 write: 1'b0, read: 1'b1};
    paddr[0] = 34'h100;
    paddr[1] = 34'h200;
    cfg[2]   = '{lock: 1'b0, mode: PMP_MODE_NA4, exec: 1'b0,
                 write: 1'b1, read: 1'b1};
    paddr[2] = 34'h104;
    cfg[5]   = cfg[2];
    paddr[5] = 34'h104;
    commit();
    issue("t3", 0, 34'h104, PMP_ACC_WRITE, PRIV_LVL_U);
    wait_rsp("t3", 0, 1, 2, 1'b1, 1'b1, 4'd1);
    issue("t3top", 0, 34'h1FC, PMP_ACC_READ, PRIV_LVL_U);
    wait_rsp("t3top", 0, 1, 2, 1'b0, 1'b1, 4'd1);
    issue("t3end", 0, 34'h200, PMP_ACC_READ, PRIV_LVL_U);
    wait_rsp("t3end", 0, 1, 5, 1'b1, 1'b0, 4'd0);

    // both channels accepted together
    chk("dual.rdy", 34'(rdy), 34'd3);
    vld   = 2'b11;
    ra[0] = 34'h1000; rt[0] = PMP_ACC_READ;  rp[0] = PRIV_LVL_M;
    ra[1] = 34'h104;  rt[1] = PMP_ACC_WRITE; rp[1] = PRIV_LVL_U;
    @(posedge clk); #1;
    vld = 2'b00;
    l0 = 0; l1 = 0; e0 = 1'b0; e1 = 1'b0; g1 = '0;
    for (int k = 1; k <= 8; k++) begin
      if (rv[0] && l0 == 0) begin l0 = k; e0 = re[0]; end
      if (rv[1] && l1 == 0) begin l1 = k; e1 = re[1]; g1 = rr[1]; end
      @(posedge clk); #1;
    end
    chk("dual.lat0", 34'(l0), 34'd5);
    chk("dual.err0", 34'(e0), 34'd0);
    chk("dual.lat1", 34'(l1), 34'd2);
    chk("dual.err1", 34'(e1), 34'd1);
    chk("dual.reg1", 34'(g1), 34'd1);

    // MML shared region L=1 R=0 W=1 X=0
    clear_cfg();
    msec.mml = 1'b1;
    cfg[3]   = '{lock: 1'b1, mode: PMP_MODE_NA4, exec: 1'b0,
                 write: 1'b1, read: 1'b0};
    paddr[3] = 34'h2000;
    commit();
    issue("t5r", 0, 34'h2000, PMP_ACC_READ, PRIV_LVL_M);
    wait_rsp("t5r", 0, 1, 2, 1'b1, 1'b1, 4'd3);
    issue("t5x", 0, 34'h2000, PMP_ACC_EXEC, PRIV_LVL_M);
    wait_rsp("t5x", 0, 1, 2, 1'b0, 1'b1, 4'd3);

    // non-MML M-mode: lock enforces missing write
    msec   = '0;
    cfg[3] = '{lock: 1'b1, mode: PMP_MODE_NA4, exec: 1'b0,
               write: 1'b0, read: 1'b1};
    commit();
    issue("lockm", 0, 34'h2000, PMP_ACC_WRITE, PRIV_LVL_M);
    wait_rsp("lockm", 0, 1, 2, 1'b1, 1'b1, 4'd3);
    cfg[3].lock = 1'b0;
    commit();
    issue("unlkm", 0, 34'h2000, PMP_ACC_WRITE, PRIV_LVL_M);
    wait_rsp("unlkm", 0, 1, 2, 1'b0, 1'b1, 4'd3);

    // MMWP default deny for M-mode
    clear_cfg();
    msec.mmwp = 1'b1;
    commit();
    issue("mmwp", 1, 34'h1000, PMP_ACC_READ, PRIV_LVL_M);
    wait_rsp("mmwp", 1, 1, 5, 1'b1, 1'b0, 4'd0);

`ifdef CVE2_PMP_HITCACHE_EN
    clear_cfg();
    set_r9(1'b0);
    commit();
    issue("c.fill", 0, 34'h0_8000_0010, PMP_ACC_WRITE, PRIV_LVL_U);
    wait_rsp("c.fill", 0, 1, 4, 1'b1, 1'b1, 4'd9);
    issue("c.hit", 0, 34'h0_8000_0010, PMP_ACC_WRITE, PRIV_LVL_U);
    wait_rsp("c.hit", 0, 1, 1, 1'b1, 1'b1, 4'd9);
    commit();
    issue("c.inv", 0, 34'h0_8000_0010, PMP_ACC_WRITE, PRIV_LVL_U);
    wait_rsp("c.inv", 0, 1, 4, 1'b1, 1'b1, 4'd9);
`endif

    // reset in the middle of a scan
    clear_cfg();
    set_r9(1'b0);
    commit();
    issue("t7", 0, 34'h0_8000_0010, PMP_ACC_WRITE, PRIV_LVL_U);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int k = 3; k <= 8; k++) begin
      if (rv[0]) seen++;
      @(posedge clk); #1;
    end
    chk("t7.norsp", 34'(seen), 34'd0);
    chk("t7.ready", 34'(rdy), 34'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
